ctrl_pipeline: RTL
==================

# ctrl_pipeline

Carries the 24-bit decoded control bundle from the decode stage through the ID/EX, EX/MEM and MEM/WB pipeline registers, and presents each field to the stage that consumes it. It also detects load-use hazards and generates operand forwarding selects. It sits directly downstream of the control unit, receiving its `control_signal`, `ID_Flush`, `Load_Byte_control` and `Store_Byte_control` outputs, and it feeds the EX, MEM and WB datapaths and the IF/ID hazard hold.

## Interface
- `CNT_W`, default 16: width of the saturating stall counter.
- `clk`  in  1  single clock; all registers update on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  the decode stage holds a real instruction.
- `id_control_signal`  in  24  control bundle, with this bit map:
  - [1:0] ALUSrc
  - [13:8] Op_code, [7:2] Funct
  - [17:14] jump/branch bits, consumed in ID and not carried
  - [18] REG_dst, [19] WB_sel_alu, [20] RegWrite
  - [21] MemWrite, [22] MemRead, [23] Rt_Rd_control
- `id_load_byte`, `id_store_byte`  in  1  byte-access qualifiers.
- `id_flush`  in  1  ID_Flush from the control unit.
- `id_rs`, `id_rt`, `id_rd`  in  5  register indices of the decode instruction.
- `ex_alu_src` out 2; `ex_alu_op` out 6; `ex_alu_funct` out 6; `ex_rt_rd_control` out 1; `ex_dest` out 5; `ex_valid` out 1. All ID/EX registers.
- `fwd_a`, `fwd_b`  out  2  combinational forwarding selects for ALU operands A (rs) and B (rt).
- `mem_mem_write`, `mem_mem_read`, `mem_load_byte`, `mem_store_byte`, `mem_reg_write` out 1; `mem_dest` out 5. All EX/MEM registers.
- `wb_reg_write`, `wb_sel_alu` out 1; `wb_dest` out 5. All MEM/WB registers.
- `load_use_stall`  out  1  combinational; the IF/ID register holds while this is high.
- `stall_count`  out  CNT_W  saturating count of load-use bubbles.

## Operation
- **Destination resolution in ID:** dest = REG_dst ? id_rt : id_rd. The block registers dest, rs and rt into ID/EX.
- **Load-use hazard:** `load_use_stall` = ex_valid & ex_mem_read & (ex_dest != 0) & (ex_dest == id_rs | ex_dest == id_rt). It is gated by id_valid.
- **Bubble insertion:** when `id_flush` or `load_use_stall` is high at an edge, ID/EX loads a bubble. A bubble has all control fields 0, valid 0 and dest 0.
- **Normal advance:** otherwise ID/EX loads the decoded fields, with valid = id_valid. Fields are zeroed when id_valid is 0.
- **Later stages:** EX/MEM and MEM/WB advance unconditionally every cycle. They carry only fields still needed downstream; for example, MemRead is dropped after MEM.
- **Forwarding, operand A (`fwd_a`):**
  - 2'b10 if mem_reg_write & mem_dest != 0 & mem_dest == ex_rs;
  - else 2'b01 if wb_reg_write & wb_dest != 0 & wb_dest == ex_rs;
  - else 2'b00.
- **Forwarding, operand B (`fwd_b`):** same rule using ex_rt.
- **Forwarding priority:** EX/MEM always wins over MEM/WB.
- **Stall counter:** `stall_count` increments at each edge where `load_use_stall` is 1, and holds at all-ones.
- **Simultaneous events:** `id_flush` together with `load_use_stall` produces one bubble, and the counter still increments.
- **Reset:** asserting `rst_n` low at any time clears every register immediately, including mid-stall. No state survives reset.

## Timing
- **Reset values:** every registered output is 0 after reset.
  - Combinational outputs then evaluate to 0: `fwd_a` = `fwd_b` = 00 and `load_use_stall` = 0.
- **Latency:** a bundle sampled at edge N appears on the ex_* outputs after edge N, on mem_* after N+1, and on wb_* after N+2.
- **Combinational paths:** `load_use_stall` and `fwd_a`/`fwd_b` settle within the cycle from the current inputs and register outputs. There is no registered delay on these paths.
- **Stall length:** a load-use stall lasts exactly one cycle. After the bubble enters ID/EX, the load is in EX/MEM with mem_mem_read, so the hazard condition clears.
- **Stall-free stream:** no bubble and no counter change.

## Structure
- **Shared package `mips_ctrl_pkg`:**
  - localparams for the control bundle bit positions;
  - FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - CTRL_W = 24.
- **Sub-module `forwarding_unit`:** purely combinational, with inputs ex_rs, ex_rt, mem_dest, mem_reg_write, wb_dest, wb_reg_write and outputs fwd_a, fwd_b. It is instantiated once.
- **In the top level:** stage registers, hazard logic and counter.

## Test plan
- **Reset:** hold `rst_n` low, drive random inputs → all outputs 0. Release → still 0 until the first valid bundle is sampled.
- **ADD pipeline:** ADD bundle (RegWrite=1, WB_sel_alu=1, REG_dst=0), rd=5, id_valid=1 → ex_dest=5 one cycle later, mem_reg_write=1 the next, then wb_reg_write=1 with wb_dest=5.
- **Load-use:** load (MemRead=1, REG_dst=1, rt=8) followed by an ADD with rs=8 → `load_use_stall`=1 for exactly one cycle and ex_valid=0 for one cycle. Then the ADD reaches EX with fwd_a=01 and stall_count=1.
- **Back-to-back ALU:** ADD writing r3, then SUB with rs=3, rt=3 → fwd_a=fwd_b=10. With an independent instruction between them → 01.
- **Register zero and flush:** a write to r0 never forwards (fwd=00) and never stalls. `id_flush`=1 → next ex_* all 0, stall_count unchanged.
- **Saturation and reset mid-stall:** with CNT_W=2, force 5 stalls → stall_count=3. Assert `rst_n` low mid-stall → counter and all stages 0 immediately.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the control pipeline: bundle bit map, forwarding
// select encodings and the per-stage register layouts.
package mips_ctrl_pkg;

    localparam int CTRL_W = 24;

    // Control bundle bit map
    localparam int ALUSRC_LSB     = 0;
    localparam int ALUSRC_MSB     = 1;
    localparam int FUNCT_LSB      = 2;
    localparam int FUNCT_MSB      = 7;
    localparam int OPCODE_LSB     = 8;
    localparam int OPCODE_MSB     = 13;
    localparam int JB_LSB         = 14;
    localparam int JB_MSB         = 17;
    localparam int REG_DST_BIT    = 18;
    localparam int WB_SEL_ALU_BIT = 19;
    localparam int REG_WRITE_BIT  = 20;
    localparam int MEM_WRITE_BIT  = 21;
    localparam int MEM_READ_BIT   = 22;
    localparam int RT_RD_CTRL_BIT = 23;

    // Forwarding select encodings
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // ID/EX register contents
    typedef struct packed {
        logic       valid;
        logic [1:0] alu_src;
        logic [5:0] alu_op;
        logic [5:0] funct;
        logic       rt_rd_control;
        logic       mem_write;
        logic       mem_read;
        logic       load_byte;
        logic       store_byte;
        logic       reg_write;
        logic       wb_sel_alu;
        logic [4:0] dest;
        logic [4:0] rs;
        logic [4:0] rt;
    } idex_t;

    // EX/MEM register contents
    typedef struct packed {
        logic       mem_write;
        logic       mem_read;
        logic       load_byte;
        logic       store_byte;
        logic       reg_write;
        logic       wb_sel_alu;
        logic [4:0] dest;
    } exmem_t;

    // MEM/WB register contents
    typedef struct packed {
        logic       reg_write;
        logic       wb_sel_alu;
        logic [4:0] dest;
    } memwb_t;

    // True when a later-stage write targets the given source register.
    // Register zero is hard-wired, so writes to it never count.
    function automatic logic dest_hit(input logic       reg_write,
                                      input logic [4:0] dest,
                                      input logic [4:0] src);
        return reg_write && (dest != 5'd0) && (dest == src);
    endfunction

endpackage

// File: rtl/ctrl_pipeline_forwarding_unit.sv
// Operand forwarding select generation for the EX stage ALU inputs.
module forwarding_unit
    import mips_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] mem_dest,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_dest,
    input  logic       wb_reg_write,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    // Pick the youngest producer: EX/MEM beats MEM/WB, otherwise register file
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (dest_hit(mem_reg_write, mem_dest, ex_rs))
            fwd_a = FWD_MEM;
        else if (dest_hit(wb_reg_write, wb_dest, ex_rs))
            fwd_a = FWD_WB;
        if (dest_hit(mem_reg_write, mem_dest, ex_rt))
            fwd_b = FWD_MEM;
        else if (dest_hit(wb_reg_write, wb_dest, ex_rt))
            fwd_b = FWD_WB;
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control pipeline: carries the decoded control bundle through ID/EX, EX/MEM
// and MEM/WB, detects load-use hazards and counts the inserted bubbles.
module ctrl_pipeline
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_control_signal,
    input  logic              id_load_byte,
    input  logic              id_store_byte,
    input  logic              id_flush,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    output logic [1:0]        ex_alu_src,
    output logic [5:0]        ex_alu_op,
    output logic [5:0]        ex_alu_funct,
    output logic              ex_rt_rd_control,
    output logic [4:0]        ex_dest,
    output logic              ex_valid,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_mem_write,
    output logic              mem_mem_read,
    output logic              mem_load_byte,
    output logic              mem_store_byte,
    output logic              mem_reg_write,
    output logic [4:0]        mem_dest,
    output logic              wb_reg_write,
    output logic              wb_sel_alu,
    output logic [4:0]        wb_dest,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  stall_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    idex_t             r_idex_p1;
    exmem_t            r_exmem_p2;
    memwb_t            r_memwb_p3;
    logic [CNT_W-1:0]  r_stall_cnt;
    idex_t             w_idex_d;
    exmem_t            w_exmem_d;
    logic              w_bubble;
    // Jump/branch bits are resolved in decode and not carried further
    logic              w_unused_jump_bits;

    assign w_unused_jump_bits = ^id_control_signal[JB_MSB:JB_LSB];

    // Load in EX whose destination feeds the decode instruction: hold IF/ID for one cycle
    assign load_use_stall = id_valid & r_idex_p1.valid & r_idex_p1.mem_read
                          & (r_idex_p1.dest != 5'd0)
                          & ((r_idex_p1.dest == id_rs) | (r_idex_p1.dest == id_rt));

    assign w_bubble = id_flush | load_use_stall;

    // Decode the ID/EX next value; flush, stall or an empty slot all give a zero bubble
    always_comb begin
        w_idex_d = '0;
        if (id_valid && !w_bubble) begin
            w_idex_d.valid         = 1'b1;
            w_idex_d.alu_src       = id_control_signal[ALUSRC_MSB:ALUSRC_LSB];
            w_idex_d.alu_op        = id_control_signal[OPCODE_MSB:OPCODE_LSB];
            w_idex_d.funct         = id_control_signal[FUNCT_MSB:FUNCT_LSB];
            w_idex_d.rt_rd_control = id_control_signal[RT_RD_CTRL_BIT];
            w_idex_d.mem_write     = id_control_signal[MEM_WRITE_BIT];
            w_idex_d.mem_read      = id_control_signal[MEM_READ_BIT];
            w_idex_d.load_byte     = id_load_byte;
            w_idex_d.store_byte    = id_store_byte;
            w_idex_d.reg_write     = id_control_signal[REG_WRITE_BIT];
            w_idex_d.wb_sel_alu    = id_control_signal[WB_SEL_ALU_BIT];
            w_idex_d.dest          = id_control_signal[REG_DST_BIT] ? id_rt : id_rd;
            w_idex_d.rs            = id_rs;
            w_idex_d.rt            = id_rt;
        end
    end

    // Project the ID/EX contents onto the fields MEM and WB still need
    always_comb begin
        w_exmem_d            = '0;
        w_exmem_d.mem_write  = r_idex_p1.mem_write;
        w_exmem_d.mem_read   = r_idex_p1.mem_read;
        w_exmem_d.load_byte  = r_idex_p1.load_byte;
        w_exmem_d.store_byte = r_idex_p1.store_byte;
        w_exmem_d.reg_write  = r_idex_p1.reg_write;
        w_exmem_d.wb_sel_alu = r_idex_p1.wb_sel_alu;
        w_exmem_d.dest       = r_idex_p1.dest;
    end

    // ---- ID -> EX boundary ----
    // Stage registers advance every cycle; ID/EX takes a bubble on flush or stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idex_p1  <= '0;
            r_exmem_p2 <= '0;
            r_memwb_p3 <= '0;
        end else begin
            r_idex_p1  <= w_idex_d;
            // ---- EX -> MEM boundary ----
            r_exmem_p2 <= w_exmem_d;
            // ---- MEM -> WB boundary ----
            r_memwb_p3 <= '{reg_write:  r_exmem_p2.reg_write,
                            wb_sel_alu: r_exmem_p2.wb_sel_alu,
                            dest:       r_exmem_p2.dest};
        end
    end

    // Count every load-use bubble, holding at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (load_use_stall)
            r_stall_cnt <= sat_inc(r_stall_cnt);
    end

    forwarding_unit u_fwd (
        .ex_rs         (r_idex_p1.rs),
        .ex_rt         (r_idex_p1.rt),
        .mem_dest      (r_exmem_p2.dest),
        .mem_reg_write (r_exmem_p2.reg_write),
        .wb_dest       (r_memwb_p3.dest),
        .wb_reg_write  (r_memwb_p3.reg_write),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    assign ex_alu_src       = r_idex_p1.alu_src;
    assign ex_alu_op        = r_idex_p1.alu_op;
    assign ex_alu_funct     = r_idex_p1.funct;
    assign ex_rt_rd_control = r_idex_p1.rt_rd_control;
    assign ex_dest          = r_idex_p1.dest;
    assign ex_valid         = r_idex_p1.valid;
    assign mem_mem_write    = r_exmem_p2.mem_write;
    assign mem_mem_read     = r_exmem_p2.mem_read;
    assign mem_load_byte    = r_exmem_p2.load_byte;
    assign mem_store_byte   = r_exmem_p2.store_byte;
    assign mem_reg_write    = r_exmem_p2.reg_write;
    assign mem_dest         = r_exmem_p2.dest;
    assign wb_reg_write     = r_memwb_p3.reg_write;
    assign wb_sel_alu       = r_memwb_p3.wb_sel_alu;
    assign wb_dest          = r_memwb_p3.dest;
    assign stall_count      = r_stall_cnt;

endmodule
